load_store_unit: RTL and testbench

//  Multicycle load/store unit between the single-cycle datapath and a word-wide data bus with valid/ready handshake.

---
 rtl/lsu_pkg.sv | 69 ++++++
 rtl/lsu_bus_if.sv | 25 ++
 rtl/lsu_load_align.sv | 30 +++
 rtl/load_store_unit.sv | 131 +++++++++++++
 tb/tb_load_store_unit.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Holds the FSM/fault enums, funct3 codes and access decoding.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } lsu_state_t;

  typedef enum logic [1:0] {
    NONE     = 2'b00,
    MISALIGN = 2'b01,
    TIMEOUT  = 2'b10,
    ILLEGAL  = 2'b11
  } lsu_fault_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Illegal encodings win over misalignment.
  function automatic lsu_fault_t check_access(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    lsu_fault_t c;
    c = NONE;
    case (f3)
      F3_B:    c = NONE;
      F3_H:    c = off[0] ? MISALIGN : NONE;
      F3_W:    c = (off != 2'b00) ? MISALIGN : NONE;
      F3_BU:   c = we ? ILLEGAL : NONE;
      F3_HU:   c = we ? ILLEGAL : (off[0] ? MISALIGN : NONE);
      default: c = ILLEGAL;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] byte_en(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(
    input logic [1:0]  sz,
    input logic [31:0] wd
  );
    logic [31:0] d;
    case (sz)
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_bus_if.sv
// Word-wide data bus with valid/ready handshake.
// The LSU is the master; memory or interconnect is the slave.
interface lsu_bus_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  bus_valid;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [3:0]            bus_be;
  logic [31:0]           bus_wdata;
  logic                  bus_ready;
  logic [31:0]           bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr,
    output bus_be, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr,
    input  bus_be, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// Load lane select and sign/zero extension.
// Purely combinational; fed by the raw bus word.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_W:    o_data = i_word;
      F3_BU:   o_data = {24'd0, w_byte};
      F3_HU:   o_data = {16'd0, w_half};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store unit: stalls the datapath while one
// access runs on the word bus, with alignment and timeout faults.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  stall,
  output logic                  done,
  output logic [31:0]           rdata,
  output logic                  fault,
  output logic [1:0]            fault_cause,
  lsu_bus_if.master             bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES);

  lsu_state_t            r_state;
  lsu_state_t            w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [2:0]            r_f3;
  logic [3:0]            r_be;
  logic [31:0]           r_wdata;
  lsu_fault_t            r_cause;
  logic [31:0]           r_rdata;
  logic [CW-1:0]         r_cnt;

  lsu_fault_t            w_cause;
  logic [31:0]           w_load;
  logic [CW-1:0]         w_cnt_inc;
  logic                  w_timeout;

  assign w_cause   = check_access(req_write, req_funct3,
                                  req_addr[1:0]);
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_timeout = (w_cnt_inc == TO_LAST);

  lsu_load_align u_align (
    .i_word   (bus.bus_rdata),
    .i_off    (r_addr[1:0]),
    .i_funct3 (r_f3),
    .o_data   (w_load)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid)
          w_next = (w_cause == NONE) ? BUS : RESP;
      end
      BUS: begin
        if (bus.bus_ready || w_timeout)
          w_next = RESP;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_cause <= NONE;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_cause <= w_cause;
            r_cnt   <= '0;
            if (w_cause == NONE) begin
              r_addr  <= req_addr;
              r_we    <= req_write;
              r_f3    <= req_funct3;
              r_be    <= byte_en(req_funct3[1:0],
                                 req_addr[1:0]);
              r_wdata <= store_data(req_funct3[1:0],
                                    req_wdata);
            end else begin
              r_rdata <= '0;
            end
          end
        end
        BUS: begin
          r_cnt <= w_cnt_inc;
          // A ready in the same cycle as the limit still completes.
          if (bus.bus_ready) begin
            r_rdata <= r_we ? '0 : w_load;
          end else if (w_timeout) begin
            r_cause <= TIMEOUT;
            r_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall = ((r_state == IDLE) && req_valid &&
                  (w_cause == NONE)) ||
                 (r_state == BUS);
  assign done        = (r_state == RESP);
  assign fault       = done && (r_cause != NONE);
  assign fault_cause = done ? r_cause : NONE;
  assign rdata       = r_rdata;

  assign bus.bus_valid = (r_state == BUS);
  assign bus.bus_we    = r_we;
  assign bus.bus_addr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign bus.bus_be    = r_be;
  assign bus.bus_wdata = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset
// corner case and random accesses against a reference model.
module tb_load_store_unit;
  import lsu_pkg::*;

  typedef struct {
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rword;
    int          waits;
    logic [1:0]  cause;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        fault;
  logic [1:0]  fault_cause;

  int n_pass  = 0;
  int n_total = 0;

  lsu_bus_if #(.ADDR_WIDTH(32)) bus ();

  load_store_unit #(
    .ADDR_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .done        (done),
    .rdata       (rdata),
    .fault       (fault),
    .fault_cause (fault_cause),
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h want %08h",
                  name, act, exp);
  endtask

  // Reference behaviour from the access rules, in plain arithmetic.
  function automatic vec_t model(
    input bit wr, input logic [2:0] f3,
    input logic [31:0] addr, input logic [31:0] wdata,
    input logic [31:0] rword, input int waits);
    vec_t v;
    int size, off;
    logic [31:0] mask, val;
    v.wr = wr; v.f3 = f3; v.addr = addr;
    v.wdata = wdata; v.rword = rword; v.waits = waits;
    off = int'(addr % 4);
    case (int'(f3 % 4))
      0: size = 1;
      1: size = 2;
      2: size = 4;
      default: size = 0;
    endcase
    if (size == 0 || (f3 > 3'd5) || (wr && f3 > 3'd3))
      v.cause = 2'd3;
    else if (off % size != 0)
      v.cause = 2'd1;
    else if (waits < 0)
      v.cause = 2'd2;
    else
      v.cause = 2'd0;
    v.be = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++)
      v.wd[8*i +: 8] = wdata[8*(i % (size == 0 ? 1 : size)) +: 8];
    v.rd = 32'd0;
    if (!wr && v.cause == 2'd0) begin
      val = rword >> (8 * off);
      if (size < 4) begin
        mask = (32'd1 << (8 * size)) - 32'd1;
        val  = val & mask;
        if (!f3[2] && val[8*size-1]) val = val | ~mask;
      end
      v.rd = val;
    end
    return v;
  endfunction

  task automatic run(input string tag, input vec_t v);
    int  bus_cnt, stall_cnt, done_at, exp_bus;
    bit  ok_bus, pre;
    logic        g_fault;
    logic [1:0]  g_cause;
    logic [31:0] g_rd;
    pre = (v.cause == 2'd1) || (v.cause == 2'd3);
    exp_bus = pre ? 0 : (v.waits < 0 ? 16 : v.waits + 1);
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    bus.bus_ready = 1'($urandom % 2);
    bus.bus_rdata = $urandom;
    #1;
    stall_cnt = int'(stall);
    bus_cnt = 0; done_at = 0; ok_bus = 1'b1;
    g_fault = 1'b0; g_cause = 2'd0; g_rd = 32'd0;
    for (int k = 1; k <= 60 && done_at == 0; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      bus.bus_ready = 1'b0;
      bus.bus_rdata = $urandom;
      #1;
      stall_cnt += int'(stall);
      if (bus.bus_valid) begin
        bus_cnt++;
        if (bus.bus_we !== v.wr ||
            bus.bus_addr !== (v.addr & ~32'h3) ||
            bus.bus_be !== v.be ||
            (v.wr && bus.bus_wdata !== v.wd))
          ok_bus = 1'b0;
        if (v.waits >= 0 && bus_cnt == v.waits + 1) begin
          bus.bus_ready = 1'b1;
          bus.bus_rdata = v.rword;
        end
      end
      if (done) begin
        done_at = k;
        g_fault = fault;
        g_cause = fault_cause;
        g_rd    = rdata;
        // A request during the done cycle must be ignored.
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = F3_W;
        req_addr   = 32'h0;
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    bus.bus_ready = 1'b0;
    #1;
    chk({tag, " bus_cycles"}, bus_cnt, exp_bus);
    chk({tag, " bus_fields"}, 32'(ok_bus), 32'd1);
    chk({tag, " stall_cycles"}, stall_cnt,
        pre ? 0 : exp_bus + 1);
    chk({tag, " done_at"}, done_at, pre ? 1 : exp_bus + 1);
    chk({tag, " fault"}, 32'(g_fault), 32'(v.cause != 0));
    chk({tag, " cause"}, 32'(g_cause), 32'(v.cause));
    if (!v.wr || v.cause != 2'd0)
      chk({tag, " rdata"}, g_rd, v.rd);
    chk({tag, " post_idle"},
        {29'd0, done, stall, bus.bus_valid}, 32'd0);
  endtask

  vec_t tbl[13];

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    bus.bus_ready = 1'b0; bus.bus_rdata = 32'd0;

    tbl[0]  = '{0, F3_W,  32'h100, 0, 32'hDEADBEEF, 0,
                2'd0, 4'hF, 0, 32'hDEADBEEF};
    tbl[1]  = '{0, F3_B,  32'h103, 0, 32'h80FFFF7F, 0,
                2'd0, 4'h8, 0, 32'hFFFFFF80};
    tbl[2]  = '{0, F3_BU, 32'h103, 0, 32'h80FFFF7F, 1,
                2'd0, 4'h8, 0, 32'h00000080};
    tbl[3]  = '{1, F3_H,  32'h202, 32'h1234ABCD, 0, 3,
                2'd0, 4'hC, 32'hABCDABCD, 0};
    tbl[4]  = '{0, F3_W,  32'h101, 0, 0, 0,
                2'd1, 4'hF, 0, 0};
    tbl[5]  = '{0, 3'b011, 32'h100, 0, 0, 0,
                2'd3, 4'hF, 0, 0};
    tbl[6]  = '{1, F3_W,  32'h300, 32'h55AA0FF0, 0, -1,
                2'd2, 4'hF, 32'h55AA0FF0, 0};
    tbl[7]  = '{0, F3_H,  32'h102, 0, 32'h80017FFF, 2,
                2'd0, 4'hC, 0, 32'hFFFF8001};
    tbl[8]  = '{0, F3_HU, 32'h102, 0, 32'h80017FFF, 0,
                2'd0, 4'hC, 0, 32'h00008001};
    tbl[9]  = '{1, F3_B,  32'h001, 32'h000000A5, 0, 1,
                2'd0, 4'h2, 32'hA5A5A5A5, 0};
    tbl[10] = '{1, F3_BU, 32'h004, 32'h1, 0, 0,
                2'd3, 4'h1, 0, 0};
    tbl[11] = '{0, F3_HU, 32'h003, 0, 0, 0,
                2'd1, 4'h0, 0, 0};
    tbl[12] = '{0, F3_B,  32'h101, 0, 32'h12345678, 0,
                2'd0, 4'h2, 0, 32'h00000056};

    @(negedge clk); #1;
    chk("reset ctl",
        {23'd0, stall, done, fault, fault_cause,
         bus.bus_valid, bus.bus_we, bus.bus_be == 4'd0},
        32'd1);
    chk("reset data", rdata | bus.bus_addr | bus.bus_wdata,
        32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++)
      run($sformatf("vec%0d", i), tbl[i]);

    // Reset while waiting on the bus.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0;
    req_funct3 = F3_W; req_addr = 32'h400;
    @(negedge clk);
    req_valid = 1'b0; bus.bus_ready = 1'b0;
    #1;
    chk("rst_pre bus_valid", 32'(bus.bus_valid), 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async outs",
        {29'd0, bus.bus_valid, stall, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run("post_rst", tbl[0]);

    for (int i = 0; i < 120; i++) begin
      bit wr;
      logic [2:0] f3;
      int w, t;
      wr = 1'($urandom % 2);
      if ($urandom % 4 == 0) begin
        f3 = 3'($urandom);
      end else begin
        t = int'($urandom % 5);
        f3 = 3'(t < 3 ? t : t + 1);
      end
      w = ($urandom % 12 == 0) ? -1 : int'($urandom_range(0, 3));
      run($sformatf("rnd%0d", i),
          model(wr, f3, $urandom & 32'hFFFF, $urandom,
                $urandom, w));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
